// File: rtl/motor_pattern_sequencer.sv
// Step-table playback engine for the H-bridge driver array.
// Plays stored multi-channel drive steps with per-channel dead time on reversal.
module motor_pattern_sequencer #(
  parameter int NUM_CHANNELS = 16,
  parameter int STEP_DEPTH   = 64,
  parameter int STEP_ADDR_W  = 6,
  parameter int DUR_W        = 16,
  parameter int LOOP_W       = 8,
  parameter int DEADTIME     = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [STEP_ADDR_W-1:0]    wr_addr,
  input  logic [2*NUM_CHANNELS-1:0] wr_pattern,
  input  logic [DUR_W-1:0]          wr_duration,
  input  logic                      wr_last,
  input  logic [1:0]                cfg_mode,
  input  logic [LOOP_W-1:0]         cfg_loops,
  input  logic                      start,
  input  logic                      stop,
  output logic [2*NUM_CHANNELS-1:0] driver_io,
  output logic                      busy,
  output logic [STEP_ADDR_W-1:0]    step_index,
  output logic                      sequence_done
);
  localparam int PW    = 2 * NUM_CHANNELS;
  localparam int MEM_N = 1 << STEP_ADDR_W;
  localparam int DT_W  = $clog2(DEADTIME + 1);
  localparam logic [STEP_ADDR_W:0]   DEPTH_L   = (STEP_ADDR_W + 1)'(STEP_DEPTH);
  localparam logic [STEP_ADDR_W-1:0] LAST_ADDR = STEP_ADDR_W'(STEP_DEPTH - 1);
  localparam logic [DT_W-1:0]        DT_LOAD   = DT_W'(DEADTIME - 1);

  typedef enum logic [1:0] {IDLE, FETCH, RUN, DONE} state_t;

  state_t                          state;
  logic [PW-1:0]                   pat_mem [MEM_N];
  logic [DUR_W-1:0]                dur_mem [MEM_N];
  logic [MEM_N-1:0]                last_mem;

  logic [1:0]                      mode_q;
  logic [LOOP_W-1:0]               loops_q;
  logic [LOOP_W-1:0]               pass_cnt;
  logic [STEP_ADDR_W-1:0]          cur_addr;
  logic [PW-1:0]                   cur_pat;
  logic                            cur_last;
  logic [DUR_W-1:0]                remain;
  logic [NUM_CHANNELS-1:0][DT_W-1:0] dt_left;

  logic                            pass_end, finish;
  logic [LOOP_W-1:0]               loop_tgt;
  logic [STEP_ADDR_W-1:0]          nxt_addr, ld_addr;
  logic [PW-1:0]                   ld_pat, old_pat, ld_drv, hold_drv;
  logic [DUR_W-1:0]                ld_dur, ld_rem;
  logic                            ld_last;
  logic [NUM_CHANNELS-1:0][DT_W-1:0] ld_dt, hold_dt;
  logic                            dt_need;

  assign wr_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign step_index = cur_addr;

  always_ff @(posedge clock) begin
    if (wr_valid && wr_ready && ({1'b0, wr_addr} < DEPTH_L)) begin
      pat_mem[wr_addr]  <= wr_pattern;
      dur_mem[wr_addr]  <= wr_duration;
      last_mem[wr_addr] <= wr_last;
    end
  end

  // Next step is read combinationally so it can be loaded on the terminal cycle.
  always_comb begin
    pass_end = cur_last || (cur_addr == LAST_ADDR);
    loop_tgt = (loops_q == '0) ? LOOP_W'(1) : loops_q;
    finish   = 1'b0;
    nxt_addr = cur_addr + 1'b1;
    if (pass_end) begin
      nxt_addr = '0;
      case (mode_q)
        2'b01:   finish = (({1'b0, pass_cnt} + 1'b1) == {1'b0, loop_tgt});
        2'b10:   finish = 1'b0;
        default: finish = 1'b1;
      endcase
    end
    ld_addr = (state == RUN) ? nxt_addr : '0;
    ld_pat  = pat_mem[ld_addr];
    ld_dur  = dur_mem[ld_addr];
    ld_last = last_mem[ld_addr];
    ld_rem  = (ld_dur == '0) ? '0 : ld_dur - 1'b1;
    old_pat = (state == RUN) ? cur_pat : '0;
    ld_drv  = '0;
    hold_drv = '0;
    ld_dt   = '0;
    hold_dt = '0;
    dt_need = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      dt_need = (ld_pat[2*i +: 2] != 2'b00) && (old_pat[2*i +: 2] != 2'b00) &&
                (ld_pat[2*i +: 2] != old_pat[2*i +: 2]);
      ld_dt[i]          = dt_need ? DT_LOAD : '0;
      ld_drv[2*i +: 2]  = dt_need ? 2'b00 : ld_pat[2*i +: 2];
      hold_dt[i]        = (dt_left[i] != '0) ? dt_left[i] - 1'b1 : '0;
      hold_drv[2*i +: 2] = (dt_left[i] != '0) ? 2'b00 : cur_pat[2*i +: 2];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      driver_io     <= '0;
      sequence_done <= 1'b0;
      mode_q        <= '0;
      loops_q       <= '0;
      pass_cnt      <= '0;
      cur_addr      <= '0;
      cur_pat       <= '0;
      cur_last      <= 1'b0;
      remain        <= '0;
      dt_left       <= '0;
    end else begin
      sequence_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            mode_q   <= cfg_mode;
            loops_q  <= cfg_loops;
            pass_cnt <= '0;
            cur_addr <= '0;
            state    <= FETCH;
          end
        end
        FETCH, RUN: begin
          if (stop || (state == RUN && remain == '0 && finish)) begin
            driver_io     <= '0;
            sequence_done <= 1'b1;
            state         <= DONE;
          end else if (state == FETCH || remain == '0) begin
            if (state == RUN && pass_end && mode_q == 2'b01) pass_cnt <= pass_cnt + 1'b1;
            cur_addr  <= ld_addr;
            cur_pat   <= ld_pat;
            cur_last  <= ld_last;
            remain    <= ld_rem;
            dt_left   <= ld_dt;
            driver_io <= ld_drv;
            state     <= RUN;
          end else begin
            remain    <= remain - 1'b1;
            dt_left   <= hold_dt;
            driver_io <= hold_drv;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_motor_pattern_sequencer.sv
// Randomised playback checks against a step-list reference model of the sequencer.
module tb_motor_pattern_sequencer;
  localparam int NC = 4, PW = 2 * NC, DEPTH = 8, AW = 4, DW = 8, LW = 4, DT = 4;

  logic clock = 1'b0, reset = 1'b1;
  logic wr_valid = 1'b0, wr_ready, wr_last = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [PW-1:0] wr_pattern = '0, driver_io;
  logic [DW-1:0] wr_duration = '0;
  logic [1:0] cfg_mode = '0;
  logic [LW-1:0] cfg_loops = '0;
  logic start = 1'b0, stop = 1'b0, busy, sequence_done;
  logic [AW-1:0] step_index;

  motor_pattern_sequencer #(.NUM_CHANNELS(NC), .STEP_DEPTH(DEPTH), .STEP_ADDR_W(AW),
    .DUR_W(DW), .LOOP_W(LW), .DEADTIME(DT)) dut (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_pattern(wr_pattern), .wr_duration(wr_duration),
    .wr_last(wr_last), .cfg_mode(cfg_mode), .cfg_loops(cfg_loops), .start(start),
    .stop(stop), .driver_io(driver_io), .busy(busy), .step_index(step_index),
    .sequence_done(sequence_done));

  always #5 clock = ~clock;

  int n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  logic [PW-1:0] m_pat [DEPTH];
  int            m_dur [DEPTH];
  bit            m_last[DEPTH];

  typedef struct { logic [PW-1:0] drv; int idx; bit dn; } exp_t;
  exp_t eq[$];

  function automatic void push(input logic [PW-1:0] d, input int idx, input bit dn);
    exp_t e;
    e.drv = d; e.idx = idx; e.dn = dn;
    eq.push_back(e);
  endfunction

  // Expected cycle-by-cycle trace: FETCH, every step cycle, then the DONE cycle.
  function automatic void build(input int mode, input int loops, input int cap);
    int addr, passes, target, len;
    bit fin;
    logic [PW-1:0] prev, code, d;
    eq.delete();
    push('0, 0, 1'b0);
    target = (loops == 0) ? 1 : loops;
    passes = 0; addr = 0; prev = '0; fin = 1'b0;
    while (!fin && eq.size() < cap) begin
      len  = (m_dur[addr] == 0) ? 1 : m_dur[addr];
      code = m_pat[addr];
      for (int c = 0; c < len; c++) begin
        d = code;
        for (int ch = 0; ch < NC; ch++)
          if (prev[2*ch +: 2] != 0 && code[2*ch +: 2] != 0 &&
              prev[2*ch +: 2] != code[2*ch +: 2] && c < DT)
            d[2*ch +: 2] = 2'b00;
        push(d, addr, 1'b0);
      end
      prev = code;
      if (m_last[addr] || addr == DEPTH - 1) begin
        if (mode == 1) begin
          passes++;
          if (passes == target) fin = 1'b1; else addr = 0;
        end else if (mode == 2) addr = 0;
        else fin = 1'b1;
      end else addr++;
    end
    push('0, -1, 1'b1);
  endfunction

  task automatic wr(input int a, input logic [PW-1:0] p, input int d, input bit l);
    @(negedge clock);
    wr_valid = 1'b1; wr_addr = AW'(a); wr_pattern = p; wr_duration = DW'(d); wr_last = l;
    chk("wr_ready_idle", wr_ready, 1);
    if (a < DEPTH) begin
      m_pat[a] = p; m_dur[a] = d; m_last[a] = l;
    end
  endtask

  task automatic play(input string tag, input int mode, input int loops, input int stop_k);
    build(mode, loops, (stop_k >= 0) ? stop_k + 2 : 4000);
    if (stop_k >= 0 && stop_k < eq.size() - 1) begin
      while (eq.size() > stop_k + 1) void'(eq.pop_back());
      push('0, -1, 1'b1);
    end
    @(negedge clock);
    wr_valid = 1'b0;
    cfg_mode = 2'(mode); cfg_loops = LW'(loops); start = 1'b1;
    for (int j = 0; j < eq.size(); j++) begin
      @(negedge clock);
      start = 1'b0; stop = 1'b0; wr_valid = 1'b0;
      chk($sformatf("%s drv[%0d]", tag, j), driver_io, eq[j].drv);
      chk($sformatf("%s done[%0d]", tag, j), sequence_done, eq[j].dn);
      chk($sformatf("%s busy[%0d]", tag, j), busy, 1);
      chk($sformatf("%s wr_ready[%0d]", tag, j), wr_ready, 0);
      if (eq[j].idx >= 0) chk($sformatf("%s idx[%0d]", tag, j), step_index, eq[j].idx);
      if (j == 1) begin
        // start, config and a table write while busy must all be ignored
        start = 1'b1; cfg_mode = 2'($urandom); cfg_loops = LW'($urandom);
        wr_valid = 1'b1; wr_addr = AW'($urandom_range(0, DEPTH - 1));
        wr_pattern = PW'($urandom); wr_duration = DW'($urandom); wr_last = 1'($urandom);
      end
      if (j == stop_k) stop = 1'b1;
    end
    @(negedge clock);
    stop = 1'b0; start = 1'b0; wr_valid = 1'b0;
    chk({tag, " idle_busy"}, busy, 0);
    chk({tag, " idle_ready"}, wr_ready, 1);
    chk({tag, " idle_done"}, sequence_done, 0);
    chk({tag, " idle_drv"}, driver_io, 0);
  endtask

  initial begin
    int len, mode, stop_k;
    repeat (3) @(negedge clock);
    chk("rst_drv", driver_io, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", step_index, 0);
    chk("rst_done", sequence_done, 0);
    chk("rst_ready", wr_ready, 1);
    reset = 1'b0;
    for (int a = 0; a < DEPTH; a++) wr(a, PW'($urandom), a + 1, 1'b0);

    // one-shot 5/1/0 table
    wr(0, 8'b00_00_00_10, 5, 1'b0);
    wr(1, 8'b00_00_10_10, 1, 1'b0);
    wr(2, 8'b00_11_10_10, 0, 1'b1);
    play("oneshot", 0, 0, -1);

    // reversal on ch0 and ch2, ch1 from off
    wr(0, 8'b00_11_00_10, 3, 1'b0);
    wr(1, 8'b00_10_10_01, 8, 1'b1);
    play("deadtime", 0, 0, -1);

    wr(0, 8'b01_10_11_10, 2, 1'b0);
    wr(1, 8'b10_01_11_01, 3, 1'b1);
    play("loop3", 1, 3, -1);
    play("loop0", 1, 0, -1);
    play("reserved", 3, 2, -1);
    play("cont_stop", 2, 0, 13);
    play("fetch_stop", 0, 0, 0);

    @(negedge clock);
    start = 1'b1; stop = 1'b1;
    @(negedge clock);
    chk("startstop_busy", busy, 0);
    start = 1'b0; stop = 1'b0;
    @(negedge clock);
    chk("startstop_busy2", busy, 0);

    @(negedge clock);
    cfg_mode = 2'b10; start = 1'b1;
    repeat (6) @(negedge clock);
    start = 1'b0; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_drv", driver_io, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_idx", step_index, 0);
    chk("midrst_done", sequence_done, 0);
    @(negedge clock);
    chk("midrst_done2", sequence_done, 0);
    chk("midrst_ready", wr_ready, 1);

    // no last bit anywhere: pass ends at the final address; out-of-range write dropped
    for (int a = 0; a < DEPTH; a++) wr(a, PW'($urandom), $urandom_range(0, 3), 1'b0);
    wr(DEPTH + 3, 8'hFF, 9, 1'b1);
    play("fulltable", 1, 2, -1);

    for (int it = 0; it < 30; it++) begin
      len = $urandom_range(1, DEPTH);
      for (int a = 0; a < DEPTH; a++)
        if ($urandom_range(0, 2) == 0 || a < len)
          wr(a, PW'($urandom), $urandom_range(0, 6), (a == len - 1) && ($urandom_range(0, 4) != 0));
      mode = $urandom_range(0, 3);
      stop_k = (mode == 2) ? $urandom_range(1, 60) :
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : -1;
      play($sformatf("rnd%0d", it), mode, $urandom_range(0, 3), stop_k);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
